// File: rtl/am25ls_decseq.sv
// Registered one-of-2^SELW decoder with load/up/down select sequencer and cascadable tc_.
// Optional output register enabled by defining DECSEQ_OUTREG_EN.
module am25ls_decseq #(
  parameter int SELW = 3
) (
  input  logic                  clk,
  input  logic                  clr_,
  input  logic [SELW-1:0]       sel,
  input  logic                  pol,
  input  logic [1:0]            mode,
  input  logic                  ce_,
  input  logic                  cet_,
  input  logic                  g1_,
  input  logic                  g2,
  input  logic                  oe_,
  output logic [(1<<SELW)-1:0]  y,
  output logic                  tc_
);

  localparam int NOUT = 1 << SELW;

  typedef enum logic [1:0] {
    M_HOLD = 2'b00,
    M_LOAD = 2'b01,
    M_UP   = 2'b10,
    M_DOWN = 2'b11
  } mode_e;

  mode_e           mode_s;
  logic [SELW-1:0] selreg_q, selreg_d;
  logic            polreg_q, polreg_d;
  logic            gate;
  logic [NOUT-1:0] yp;
  logic [NOUT-1:0] ypol;
  logic [NOUT-1:0] yout;

  assign mode_s = mode_e'(mode);

  always_comb begin
    selreg_d = selreg_q;
    polreg_d = polreg_q;
    if (!ce_) begin
      unique case (mode_s)
        M_HOLD: ;
        M_LOAD: begin
          selreg_d = sel;
          polreg_d = pol;
        end
        M_UP:   if (!cet_) selreg_d = selreg_q + 1'b1;
        M_DOWN: if (!cet_) selreg_d = selreg_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      selreg_q <= '0;
      polreg_q <= 1'b0;
    end else begin
      selreg_q <= selreg_d;
      polreg_q <= polreg_d;
    end
  end

  assign gate = ~g1_ & g2;

  always_comb begin
    yp = '1;
    if (gate) yp[selreg_q] = 1'b0;
  end

  assign ypol = polreg_q ? ~yp : yp;

`ifdef DECSEQ_OUTREG_EN
  logic [NOUT-1:0] yreg_q;

  // Captures every edge regardless of ce_, so gate changes still reach y one cycle later.
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) yreg_q <= '1;
    else       yreg_q <= ypol;
  end

  assign yout = yreg_q;
`else
  assign yout = ypol;
`endif

  assign y = oe_ ? {NOUT{1'bz}} : yout;

  // Terminal count looks only at mode/cet_/selreg so cascades ripple within one cycle.
  assign tc_ = ~(~cet_ & (((mode_s == M_UP) && (&selreg_q)) ||
                          ((mode_s == M_DOWN) && (selreg_q == '0))));

endmodule

// File: tb/tb_am25ls_decseq.sv
// Directed bench for am25ls_decseq: reset, load/polarity/gating, up/down wrap, tc_, clear, cascade.
module tb_am25ls_decseq;

  logic       clk = 1'b0;
  logic       clr_;
  logic [2:0] sel;
  logic       pol;
  logic [1:0] mode;
  logic       ce_, cet_, g1_, g2, oe_;
  wire  [7:0] y;
  wire        tc_;

  logic       clr_c;
  wire  [3:0] y0, y1;
  wire        tc0, tc1;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] HOLD = 2'b00, LOAD = 2'b01, UP = 2'b10, DOWN = 2'b11;

  always #5 clk = ~clk;

  am25ls_decseq #(.SELW(3)) dut (
    .clk(clk), .clr_(clr_), .sel(sel), .pol(pol), .mode(mode), .ce_(ce_),
    .cet_(cet_), .g1_(g1_), .g2(g2), .oe_(oe_), .y(y), .tc_(tc_)
  );

  am25ls_decseq #(.SELW(2)) c0 (
    .clk(clk), .clr_(clr_c), .sel(2'b00), .pol(1'b0), .mode(UP), .ce_(1'b0),
    .cet_(1'b0), .g1_(1'b0), .g2(1'b1), .oe_(1'b0), .y(y0), .tc_(tc0)
  );

  am25ls_decseq #(.SELW(2)) c1 (
    .clk(clk), .clr_(clr_c), .sel(2'b00), .pol(1'b0), .mode(UP), .ce_(1'b0),
    .cet_(tc0), .g1_(1'b0), .g2(1'b1), .oe_(1'b0), .y(y1), .tc_(tc1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] one4;
    logic [3:0] e0, e1;
    logic [7:0] tcb;
    clr_ = 1'b0; clr_c = 1'b0;
    sel = 3'd0; pol = 1'b0; mode = HOLD; ce_ = 1'b0; cet_ = 1'b1;
    g1_ = 1'b0; g2 = 1'b1; oe_ = 1'b0;
    #1;
    check("rst_y", y, 8'hFE);
    check("rst_tc", {7'd0, tc_}, 8'd1);
    #1 clr_ = 1'b1;
    tick;
    check("hold_y", y, 8'hFE);
    oe_ = 1'b1; #1;
    check("oe_off", {7'd0, (y !== 8'hFE)}, 8'd1);
    oe_ = 1'b0;
    mode = DOWN; cet_ = 1'b0; #1;
    check("tc_down0", {7'd0, tc_}, 8'd0);
    cet_ = 1'b1; #1;
    check("tc_cet_off", {7'd0, tc_}, 8'd1);

    mode = LOAD; sel = 3'd5; pol = 1'b0;
    tick;
    check("load5_p0", y, 8'hDF);
    pol = 1'b1;
    tick;
    check("load5_p1", y, 8'h20);
    g2 = 1'b0; #1;
    check("gate_off_p1", y, 8'h00);
    g2 = 1'b1;

    pol = 1'b0; sel = 3'd6;
    tick;
    check("load6", y, 8'hBF);
    mode = UP; cet_ = 1'b0; #1;
    check("tc_up6", {7'd0, tc_}, 8'd1);
    tick;
    check("up7_y", y, 8'h7F);
    check("up7_tc", {7'd0, tc_}, 8'd0);
    tick;
    check("upwrap_y", y, 8'hFE);
    check("upwrap_tc", {7'd0, tc_}, 8'd1);
    tick;
    check("up1_y", y, 8'hFD);
    cet_ = 1'b1;
    tick;
    check("cet_hold", y, 8'hFD);
    cet_ = 1'b0; ce_ = 1'b1;
    tick;
    check("ce_hold", y, 8'hFD);
    ce_ = 1'b0;

    mode = LOAD; sel = 3'd0;
    tick;
    mode = DOWN; #1;
    check("tc_down_pre", {7'd0, tc_}, 8'd0);
    tick;
    check("downwrap_y", y, 8'h7F);
    check("downwrap_tc", {7'd0, tc_}, 8'd1);
    tick;
    check("down6_y", y, 8'hBF);

    mode = LOAD; sel = 3'd7;
    tick;
    sel = 3'd3; #1;
    check("tc_load7", {7'd0, tc_}, 8'd1);
    tick;
    check("load_wins", y, 8'hF7);

    pol = 1'b1;
    tick;
    mode = UP;
    tick;
    check("up4_p1", y, 8'h10);
    #2 clr_ = 1'b0; #1;
    check("clr_async", y, 8'hFE);
    tick;
    check("clr_held", y, 8'hFE);
    clr_ = 1'b1;
    tick;
    check("clr_up1", y, 8'hFD);

    clr_c = 1'b1;
    one4 = 4'd1;
    for (int k = 1; k <= 17; k++) begin
      tick;
      e0 = ~(one4 << (k % 4));
      e1 = ~(one4 << ((k / 4) % 4));
      check($sformatf("casc_lo_%0d", k), {4'd0, y0}, {4'd0, e0});
      check($sformatf("casc_hi_%0d", k), {4'd0, y1}, {4'd0, e1});
    end
    tcb = {6'd0, tc1, tc0};
    check("casc_tc", tcb, 8'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
